// File: rtl/fc_requant_streamer.sv
// Captures one parallel vector of post-ReLU neuron outputs and streams it out
// one element per cycle, requantized with a rounding right-shift and saturation.
module fc_requant_streamer #(
    parameter int WIDTH = 8,
    parameter int IN    = 128,
    parameter int N     = 84,
    parameter int SHIFT = 7,
    localparam int ACC_W = WIDTH * 2 + $clog2(IN),
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] in_data [0:N-1],
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last
);

    // Handshake: a vector moves on a clock edge where in_valid && in_ready;
    // an element moves on a clock edge where out_valid && out_ready. Outputs
    // hold stable while out_valid && !out_ready.

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [ACC_W:0]   ONE      = 1;
    localparam logic [ACC_W:0]   RND      = ONE << (SHIFT - 1);
    localparam logic [WIDTH-1:0] MAX_OUT  = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic [ACC_W:0]   MAX_WIDE = {{(ACC_W + 1 - WIDTH){1'b0}}, MAX_OUT};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0] bank_q [0:N-1];
    logic [ACC_W-1:0] bank_d [0:N-1];
    logic             is_last;

    // The extra top bit of the sum keeps the rounding add from overflowing.
    function automatic logic [WIDTH-1:0] requant(input logic [ACC_W-1:0] v);
        logic [ACC_W:0] r;
        r = ({1'b0, v} + RND) >> SHIFT;
        if (v[ACC_W-1]) begin
            return '0;
        end else if (r > MAX_WIDE) begin
            return MAX_OUT;
        end else begin
            return r[WIDTH-1:0];
        end
    endfunction

    assign is_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        idx_d       = idx_q;
        bank_d      = bank_q;
        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    bank_d      = in_data;
                    idx_d       = '0;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = STREAM;
                end
            end
            STREAM: begin
                if (out_valid_q && out_ready) begin
                    if (is_last) begin
                        idx_d       = '0;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            bank_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
            bank_q      <= bank_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = requant(bank_q[idx_q]);
    assign out_index = idx_q;
    assign out_last  = out_valid_q && is_last;

endmodule

// File: tb/tb_fc_requant_streamer.sv
// Self-checking bench for fc_requant_streamer: directed steps with random data,
// checked against an arithmetic reference model and an expected-value queue.
module tb_fc_requant_streamer;

    localparam int WIDTH = 8;
    localparam int IN    = 128;
    localparam int N     = 84;
    localparam int SHIFT = 7;
    localparam int ACC_W = 23;
    localparam int IDX_W = 7;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] in_data [0:N-1];
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDX_W-1:0] out_index;
    logic             out_last;

    logic [WIDTH-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_fail   = 0;
    int               cyc      = 0;

    logic [ACC_W-1:0] dir_v [9] = '{23'd63, 23'd64, 23'd191, 23'd192, 23'd0,
                                    23'd16256, 23'd16320, 23'h3FFFFF, 23'h400000};
    logic [WIDTH-1:0] dir_e [9] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd0,
                                    8'd127, 8'd127, 8'd127, 8'd0};

    fc_requant_streamer #(
        .WIDTH(WIDTH), .IN(IN), .N(N), .SHIFT(SHIFT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_index(out_index),
        .out_last (out_last)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // reference model: plain integer arithmetic on the value
    function automatic logic [WIDTH-1:0] model(input logic [ACC_W-1:0] v);
        int r;
        if (int'(v) >= 2 ** (ACC_W - 1)) return '0;
        r = (int'(v) + 2 ** (SHIFT - 1)) / (2 ** SHIFT);
        if (r > 2 ** (WIDTH - 1) - 1) r = 2 ** (WIDTH - 1) - 1;
        return WIDTH'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [ACC_W-1:0] rand_word();
        logic [ACC_W-1:0] w;
        case ($urandom_range(0, 3))
            0:       w = ACC_W'($urandom_range(0, 255));
            1:       w = ACC_W'($urandom_range(0, 20000));
            2:       w = ACC_W'($urandom_range(16200, 16400));
            default: w = ACC_W'($urandom);
        endcase
        return w;
    endfunction

    task automatic fill_random();
        for (int k = 0; k < N; k++) in_data[k] = rand_word();
    endtask

    // driver: offer the vector and push model expectations for elements >= model_from
    task automatic capture_vec(input bit hold, input bit scramble, input int model_from,
                               output int waits);
        waits    = 0;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            waits++;
        end while (!in_ready && waits < 400);
        check("capture_in_ready", in_ready, 1);
        for (int k = model_from; k < N; k++) exp_q.push_back(model(in_data[k]));
        if (!hold) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (scramble) fill_random();
        end
    endtask

    // driver + scoreboard: drain the stream, optionally stopping at index stop_at
    task automatic consume(input int stop_at, input bit rnd, output int first_cyc);
        int               exp_idx = 0;
        int               iters   = 0;
        bit               stalled = 1'b0;
        logic [WIDTH-1:0] pd      = '0;
        logic [IDX_W-1:0] pi      = '0;
        logic [WIDTH-1:0] e;
        first_cyc = -1;
        while (exp_idx < N && iters < 20 * N) begin
            @(negedge clk);
            iters++;
            if (stalled) begin
                check("stall_data", out_data, pd);
                check("stall_index", out_index, pi);
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                e = (exp_q.size() > 0) ? exp_q[0] : 'x;
                check("data", out_data, e);
                check("index", out_index, exp_idx);
                check("last", out_last, (exp_idx == N - 1));
                if (exp_idx == stop_at) begin
                    out_ready = 1'b0;
                    break;
                end
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    exp_idx++;
                end else begin
                    stalled = 1'b1;
                    pd      = out_data;
                    pi      = out_index;
                end
            end else begin
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        check("stream_count", exp_idx, (stop_at < 0) ? N : stop_at);
    endtask

    initial begin
        int w, fa, fb;

        // reset state, ramp vector held on in_valid through reset
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) in_data[k] = ACC_W'(k * 128);
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_index", out_index, 0);
        check("rst_out_last", out_last, 0);

        // ramp: element k*128 requantizes to k; in_data scrambled after capture
        rst = 1'b0;
        for (int k = 0; k < N; k++) exp_q.push_back(WIDTH'(k));
        capture_vec(1'b0, 1'b1, N, w);
        check("ready_after_release", w, 1);
        check("post_capture_in_ready", in_ready, 0);
        check("post_capture_out_valid", out_valid, 1);
        consume(-1, 1'b0, fa);
        @(negedge clk);
        check("idle_out_valid", out_valid, 0);
        check("idle_in_ready", in_ready, 1);

        // rounding, saturation and clamp corner values, then random remainder
        fill_random();
        for (int k = 0; k < 9; k++) begin
            in_data[k] = dir_v[k];
            exp_q.push_back(dir_e[k]);
        end
        capture_vec(1'b0, 1'b1, 9, w);
        consume(-1, 1'b0, fa);

        // random backpressure, two vectors
        for (int v = 0; v < 2; v++) begin
            fill_random();
            capture_vec(1'b0, 1'b1, 0, w);
            consume(-1, 1'b1, fa);
        end

        // back-to-back vectors with in_valid held and out_ready always high
        repeat (2) @(negedge clk);
        out_ready = 1'b1;
        fill_random();
        capture_vec(1'b1, 1'b0, 0, w);
        consume(-1, 1'b0, fa);
        fill_random();
        capture_vec(1'b1, 1'b0, 0, w);
        check("b2b_gap_cycles", w, 1);
        check("b2b_gap_out_valid", out_valid, 0);
        consume(-1, 1'b0, fb);
        in_valid = 1'b0;
        check("b2b_period", fb - fa, N + 1);

        // reset in the middle of a stream
        repeat (2) @(negedge clk);
        fill_random();
        capture_vec(1'b0, 1'b1, 0, w);
        consume(40, 1'b1, fa);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_index", out_index, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_out_last", out_last, 0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        fill_random();
        capture_vec(1'b0, 1'b1, 0, w);
        check("midrst_ready_after_release", w, 1);
        consume(-1, 1'b0, fa);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
